// File: rtl/sram_like_master_pkg.sv
// sram_like_master_pkg: state and bus-size encodings shared by the sram-like initiator
// and its bench, plus the write-detect helper.
package sram_like_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    function automatic logic is_write(input logic [3:0] wen);
        return |wen;
    endfunction

endpackage

// File: rtl/sram_like_master_pff.sv
// sram_like_master_pff: clear-capable pipeline register with load enable,
// used for the request-capture fields and the read-data hold register.
module sram_like_master_pff #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q, q_d;

    always_comb q_d = clr ? '0 : en ? d : q_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) q_q <= '0;
        else         q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/sram_like_master.sv
// sram_like_master: turns one pipeline memory access into one sram-like bus transaction and
// stalls the stage until data returns. Define SRAM_LIKE_FAST_REQ_EN to issue req straight from IDLE.
module sram_like_master
    import sram_like_master_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_en,
    input  logic [3:0]        cpu_wen,
    input  logic [1:0]        cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_flush,
    input  logic              cpu_hold,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              req,
    output logic              wr,
    output logic [1:0]        size,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic              addr_ok,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] rdata
);

    localparam int CAP_W = 3 + ADDR_W + DATA_W;

    state_e            state_q, state_d;
    logic              cancel_q, cancel_d;
    logic              req_q, req_d;
    logic              cap_en, rd_en, abort, fast_hit;
    logic [CAP_W-1:0]  cap_q;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    sram_like_master_pff #(.W(CAP_W)) u_cap (
        .clk    (clk),
        .resetn (resetn),
        .en     (cap_en),
        .clr    (1'b0),
        .d      ({is_write(cpu_wen), cpu_size, cpu_addr, cpu_wdata}),
        .q      (cap_q)
    );

    assign {wr_q, size_q, addr_q, wdata_q} = cap_q;

    sram_like_master_pff #(.W(DATA_W)) u_rdata (
        .clk    (clk),
        .resetn (resetn),
        .en     (rd_en),
        .clr    (1'b0),
        .d      (rdata),
        .q      (cpu_rdata)
    );

    // An issued request can never be withdrawn, so flush or a dropped cpu_en only marks it cancelled.
    always_comb begin
        cap_en   = (state_q == IDLE) & cpu_en & ~cpu_flush;
        abort    = cpu_flush | ~cpu_en;
`ifdef SRAM_LIKE_FAST_REQ_EN
        fast_hit = cap_en & addr_ok;
`else
        fast_hit = 1'b0;
`endif
        state_d  = state_q;
        cancel_d = cancel_q;
        rd_en    = 1'b0;
        case (state_q)
            IDLE: state_d = fast_hit ? WAIT : cap_en ? REQ : IDLE;
            REQ: begin
                cancel_d = cancel_q | abort;
                state_d  = addr_ok ? WAIT : REQ;
            end
            WAIT: begin
                cancel_d = data_ok ? 1'b0 : cancel_q | abort;
                rd_en    = data_ok & ~wr_q & ~cancel_q & ~abort;
                state_d  = ~data_ok ? WAIT : (cancel_q | abort) ? IDLE : DONE;
            end
            default: state_d = (~cpu_hold | cpu_flush) ? IDLE : DONE;
        endcase
        req_d = state_d == REQ;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cancel_q <= 1'b0;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            req_q    <= req_d;
        end
    end

`ifdef SRAM_LIKE_FAST_REQ_EN
    logic fast;
    assign fast  = (state_q == IDLE) & resetn;
    assign req   = fast ? cap_en : req_q;
    assign wr    = fast ? is_write(cpu_wen) : wr_q;
    assign size  = fast ? cpu_size : size_q;
    assign addr  = fast ? cpu_addr : addr_q;
    assign wdata = fast ? cpu_wdata : wdata_q;
`else
    assign req   = req_q;
    assign wr    = wr_q;
    assign size  = size_q;
    assign addr  = addr_q;
    assign wdata = wdata_q;
`endif

    assign cpu_stall = cpu_en & (state_q != DONE);

endmodule

// File: tb/tb_sram_like_master.sv
// tb_sram_like_master: directed plus randomized transactions against a latency/data reference model.
module tb_sram_like_master;
    import sram_like_master_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cpu_en = 1'b0, cpu_flush = 1'b0, cpu_hold = 1'b0;
    logic [3:0]  cpu_wen = '0;
    logic [1:0]  cpu_size = '0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall, req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        addr_ok = 1'b0, data_ok = 1'b0;
    logic [31:0] rdata = '0;

    int checks = 0;
    int failures = 0;
    logic [31:0] model_rdata = '0;

`ifdef SRAM_LIKE_FAST_REQ_EN
    localparam int BASE_STALL = 2;
`else
    localparam int BASE_STALL = 3;
`endif

    sram_like_master dut (
        .clk       (clk),
        .resetn    (resetn),
        .cpu_en    (cpu_en),
        .cpu_wen   (cpu_wen),
        .cpu_size  (cpu_size),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_flush (cpu_flush),
        .cpu_hold  (cpu_hold),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .req       (req),
        .wr        (wr),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
        .addr_ok   (addr_ok),
        .data_ok   (data_ok),
        .rdata     (rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cpu_en = 0; cpu_flush = 0; cpu_hold = 0; addr_ok = 0; data_ok = 0;
            #1;
            chk("idle_stall", cpu_stall, 0);
            chk("idle_req", req, 0);
            chk("idle_rdata", cpu_rdata, model_rdata);
        end
    endtask

    // fmode: 0 none, 1 flush on accept in REQ, 2 flush with data_ok, 3 flush in first WAIT cycle, 4 drop cpu_en there
    task automatic run_txn(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input logic [1:0] sz, input int a_dly,
                           input int d_dly, input int hold_n, input int fmode);
        int c_req, c_wait, c_stall, c_hold, budget;
        bit accepted, got, got_now, finished, stable, saw_done;
        logic [31:0] exp_rd;
        c_req = 0; c_wait = 0; c_stall = 0; c_hold = 0; budget = 0;
        accepted = 0; got = 0; got_now = 0; finished = 0; stable = 1; saw_done = 0;
        exp_rd = (fmode == 0 && wen == 4'h0) ? rd : model_rdata;
        @(posedge clk); #1;
        cpu_wen = wen; cpu_addr = a; cpu_wdata = wd; cpu_size = sz;
        while (!finished && budget < 100) begin
            cpu_en = 1; cpu_flush = 0; cpu_hold = 0; addr_ok = 0; data_ok = 0;
            #1;
            got_now = 0;
            if (accepted && !got) begin
                c_wait++;
                if (c_wait == d_dly + 1) begin data_ok = 1; rdata = rd; got = 1; got_now = 1; end
            end
            if (req === 1'b1) begin
                c_req++;
                if (addr !== a || wdata !== wd || wr !== (|wen) || size !== sz) stable = 0;
                if (c_req == a_dly + 1) begin addr_ok = 1; accepted = 1; end
            end
            cpu_flush = (fmode == 1 && addr_ok) || (fmode == 2 && data_ok) ||
                        (fmode == 3 && accepted && c_wait == 1);
            if (fmode == 4 && accepted && c_wait == 1) cpu_en = 0;
            #1;
            if (cpu_en && !cpu_stall) begin
                if (fmode != 0) saw_done = 1;
                else begin
                    chk("done_rdata", cpu_rdata, exp_rd);
                    chk("done_req_lo", req, 0);
                    cpu_hold = c_hold < hold_n;
                    if (cpu_hold) c_hold++;
                    else finished = 1;
                end
            end else if (cpu_stall) c_stall++;
            if (fmode != 0 && got_now) finished = 1;
            budget++;
            if (!finished) begin @(posedge clk); #1; end
        end
        chk("txn_finished", finished, 1);
        chk("req_cycles", c_req, a_dly + 1);
        chk("fields_stable", stable, 1);
        model_rdata = exp_rd;
        if (fmode == 0) begin
            chk("stall_cycles", c_stall, BASE_STALL + a_dly + d_dly);
            chk("rdata_after", cpu_rdata, model_rdata);
        end else begin
            chk("no_done", saw_done, 0);
            @(posedge clk); #1;
            cpu_en = 1; cpu_flush = 1; cpu_hold = 0; addr_ok = 0; data_ok = 0;
            #1;
            chk("flush_idle_stall", cpu_stall, 1);
            chk("flush_idle_req", req, 0);
            chk("flush_rdata", cpu_rdata, model_rdata);
        end
    endtask

    initial begin
        int fm, ad;
        logic [3:0] w;
        #1;
        chk("rst_stall_lo", cpu_stall, 0);
        cpu_en = 1;
        #1;
        chk("rst_stall_en", cpu_stall, 1);
        chk("rst_req", req, 0);
        chk("rst_wr", wr, 0);
        chk("rst_size", size, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_rdata", cpu_rdata, 0);
        cpu_en = 0;
        @(negedge clk) resetn = 1;

        run_txn(4'h0, 32'h1FC0_0000, 32'h0, 32'h3C08_BFC0, SIZE_W, 0, 0, 0, 0);
        run_txn(4'hF, 32'hA000_0010, 32'hDEAD_BEEF, 32'h0, SIZE_W, 4, 0, 0, 0);
        run_txn(4'h0, 32'h8000_0040, 32'h0, 32'h1234_5678, SIZE_W, 1, 2, 0, 3);
        run_txn(4'h0, 32'h8000_0080, 32'h0, 32'hA5A5_A5A5, SIZE_W, 0, 0, 3, 0);
        run_txn(4'h0, 32'h8000_00C0, 32'h0, 32'h0BAD_F00D, SIZE_H, 0, 1, 0, 2);
        run_txn(4'h0, 32'h8000_0100, 32'h0, 32'h7777_0000, SIZE_B, 2, 1, 0, 1);
        run_txn(4'h0, 32'h8000_0140, 32'h0, 32'h5555_AAAA, SIZE_W, 0, 2, 1, 4);
        idle(2);

        for (int i = 0; i < 40; i++) begin
            fm = $urandom_range(0, 9);
            fm = fm < 6 ? 0 : fm - 5;
            w = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            ad = $urandom_range(0, 4);
            if (fm == 1 && ad == 0) ad = 1;
            run_txn(w, $urandom, $urandom, $urandom, 2'($urandom_range(0, 2)), ad,
                    $urandom_range(0, 3), $urandom_range(0, 3), fm);
            idle($urandom_range(0, 2));
        end

        @(posedge clk); #1;
        cpu_en = 1; cpu_wen = 4'h3; cpu_size = SIZE_H; cpu_addr = 32'h0000_1234;
        cpu_wdata = 32'hCAFE_0001; cpu_flush = 0; cpu_hold = 0; addr_ok = 0; data_ok = 0;
        @(posedge clk); #1;
        chk("pre_rst_req", req, 1);
        #2 resetn = 0;
        #1;
        chk("mid_rst_req", req, 0);
        chk("mid_rst_wr", wr, 0);
        chk("mid_rst_size", size, 0);
        chk("mid_rst_addr", addr, 0);
        chk("mid_rst_wdata", wdata, 0);
        chk("mid_rst_rdata", cpu_rdata, 0);
        chk("mid_rst_stall", cpu_stall, 1);
        model_rdata = '0;
        cpu_en = 0;
        @(negedge clk) resetn = 1;
        idle(1);
        run_txn(4'h0, 32'h1FC0_0004, 32'h0, 32'h2408_0001, SIZE_W, 1, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
